// File: rtl/npc_pc_if.sv
// Fetch-side bundle between ID redirect sources and the PC unit.
// Master drives resolved redirects and stall; slave returns the fetch PC.
interface npc_pc_if;
    logic        stall;
    logic        br_valid;
    logic        br_taken;
    logic [31:0] br_offset;
    logic [31:0] id_pc;
    logic        j_valid;
    logic [25:0] j_index;
    logic        jr_valid;
    logic [31:0] jr_target;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic        redirect_pending;
    logic        exc;
    logic [31:0] exc_epc;

    modport master (
        output stall, br_valid, br_taken, br_offset, id_pc,
        output j_valid, j_index, jr_valid, jr_target,
        input  pc, pc_plus4, redirect_pending, exc, exc_epc
    );

    modport slave (
        input  stall, br_valid, br_taken, br_offset, id_pc,
        input  j_valid, j_index, jr_valid, jr_target,
        output pc, pc_plus4, redirect_pending, exc, exc_epc
    );
endinterface

// File: rtl/npc_pc_unit.sv
// IF-stage PC with delayed-branch next-PC select and stall-time redirect buffer.
// Optional misaligned-jr exception enabled by defining PC_EXC_EN.
module npc_pc_unit #(
    parameter logic [31:0] RESET_PC   = 32'h0000_3000,
    parameter logic [31:0] EXC_VECTOR = 32'h0000_4180
) (
    input  logic      clk,
    input  logic      rst_n,
    npc_pc_if.slave   bus
);

    typedef enum logic {RUN, HOLD} state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] pend_q, pend_d;
    logic [31:0] id_plus4;
    logic [31:0] tgt;
    logic        redirect;

    always_comb begin
        id_plus4 = bus.id_pc + 32'd4;
        redirect = bus.jr_valid | bus.j_valid
                 | (bus.br_valid & bus.br_taken);
        if (bus.jr_valid)
            tgt = bus.jr_target;
        else if (bus.j_valid)
            tgt = {id_plus4[31:28], bus.j_index, 2'b00};
        else
            tgt = id_plus4 + bus.br_offset;
`ifndef PC_EXC_EN
        tgt[1:0] = 2'b00;
`endif
    end

`ifdef PC_EXC_EN
    logic        exc_q, exc_d;
    logic [31:0] epc_q, epc_d;
    logic        exc_hit;

    assign exc_hit = bus.jr_valid & (bus.jr_target[1:0] != 2'b00);
`else
    logic unused_exc_vector;

    assign unused_exc_vector = ^EXC_VECTOR;
`endif

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        pend_d  = pend_q;
`ifdef PC_EXC_EN
        exc_d   = 1'b0;
        epc_d   = epc_q;
`endif
        case (state_q)
            RUN: begin
                if (!bus.stall) begin
                    pc_d = redirect ? tgt : pc_q + 32'd4;
                end else if (redirect) begin
                    pend_d  = tgt;
                    state_d = HOLD;
                end
            end
            HOLD: begin
                // ID is frozen while held; its redirect was already captured
                if (!bus.stall) begin
                    pc_d    = pend_q;
                    state_d = RUN;
                end
            end
            default: state_d = RUN;
        endcase
`ifdef PC_EXC_EN
        if (state_q == RUN && exc_hit) begin
            pc_d    = EXC_VECTOR;
            pend_d  = pend_q;
            state_d = RUN;
            exc_d   = 1'b1;
            epc_d   = bus.jr_target;
        end
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= RUN;
            pc_q    <= RESET_PC;
            pend_q  <= 32'd0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            pend_q  <= pend_d;
        end
    end

`ifdef PC_EXC_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            exc_q <= 1'b0;
            epc_q <= 32'd0;
        end else begin
            exc_q <= exc_d;
            epc_q <= epc_d;
        end
    end

    assign bus.exc     = exc_q;
    assign bus.exc_epc = epc_q;
`else
    assign bus.exc     = 1'b0;
    assign bus.exc_epc = 32'd0;
`endif

    assign bus.pc               = pc_q;
    assign bus.pc_plus4         = pc_q + 32'd4;
    assign bus.redirect_pending = (state_q == HOLD);

endmodule

// File: tb/tb_npc_pc_unit.sv
// Scoreboard bench for npc_pc_unit: directed cases then random traffic.
// A behavioural model predicts each fetch PC; a monitor compares per cycle.
module tb_npc_pc_unit;

    localparam logic [31:0] RST_PC = 32'h0000_3000;
    localparam logic [31:0] EXC_VEC = 32'h0000_4180;
`ifdef PC_EXC_EN
    localparam bit EXC_EN = 1'b1;
`else
    localparam bit EXC_EN = 1'b0;
`endif

    typedef struct {
        logic [31:0] pc;
        logic        pend;
        logic        exc;
        logic [31:0] epc;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    npc_pc_if bus ();

    npc_pc_unit dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    exp_t q[$];
    int   n_chk = 0;
    int   n_pass = 0;

    logic [31:0] m_pc;
    logic        m_hold;
    logic [31:0] m_pend;
    logic        m_exc;
    logic [31:0] m_epc;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] req);
        n_chk++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got %08h expected %08h", nm, act, req);
    endtask

    always @(posedge clk) begin
        exp_t e;
        #1;
        if (q.size() > 0) begin
            e = q.pop_front();
            chk("pc", bus.pc, e.pc);
            chk("pc_plus4", bus.pc_plus4, e.pc + 32'd4);
            chk("redirect_pending", {31'd0, bus.redirect_pending},
                {31'd0, e.pend});
            chk("exc", {31'd0, bus.exc}, {31'd0, e.exc});
            chk("exc_epc", bus.exc_epc, e.epc);
        end
    end

    function automatic exp_t snap();
        exp_t e;
        e.pc = m_pc;
        e.pend = m_hold;
        e.exc = m_exc;
        e.epc = m_epc;
        return e;
    endfunction

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        bus.stall = 0; bus.br_valid = 0; bus.br_taken = 0;
        bus.br_offset = 0; bus.id_pc = 0; bus.j_valid = 0;
        bus.j_index = 0; bus.jr_valid = 0; bus.jr_target = 0;
        m_pc = RST_PC; m_hold = 0; m_pend = 0; m_exc = 0; m_epc = 0;
        #1;
        chk("reset_async_pc", bus.pc, RST_PC);
        q.push_back(snap());
    endtask

    task automatic step(input logic st, input logic bv, input logic bt,
                        input logic [31:0] boff, input logic [31:0] idpc,
                        input logic jv, input logic [25:0] jidx,
                        input logic jrv, input logic [31:0] jrt);
        logic [31:0] t;
        logic        redir;
        @(negedge clk);
        rst_n = 1'b1;
        bus.stall = st; bus.br_valid = bv; bus.br_taken = bt;
        bus.br_offset = boff; bus.id_pc = idpc; bus.j_valid = jv;
        bus.j_index = jidx; bus.jr_valid = jrv; bus.jr_target = jrt;
        redir = jrv || jv || (bv && bt);
        if (jrv) t = jrt;
        else if (jv) t = ((idpc + 4) & 32'hF000_0000) + ({6'd0, jidx} * 4);
        else t = idpc + 4 + boff;
        if (!EXC_EN) t = t & ~32'd3;
        m_exc = 0;
        if (m_hold) begin
            if (!st) begin
                m_pc = m_pend;
                m_hold = 0;
            end
        end else if (EXC_EN && jrv && (jrt % 4 != 0)) begin
            m_pc = EXC_VEC;
            m_exc = 1;
            m_epc = jrt;
        end else if (!st) begin
            m_pc = redir ? t : m_pc + 4;
        end else if (redir) begin
            m_hold = 1;
            m_pend = t;
        end
        q.push_back(snap());
    endtask

    task automatic idle(input logic st);
        step(st, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        int wait_cyc;
        logic [31:0] r;
        do_reset();
        idle(0); idle(0); idle(0);
        // mid-run reset, then the free-running sequence again
        do_reset();
        idle(0); idle(0); idle(0);
        step(0, 1, 1, 32'hFFFF_FFF8, 32'h3008, 0, 0, 0, 0);
        step(0, 1, 0, 32'hFFFF_FFF8, 32'h3008, 0, 0, 0, 0);
        step(0, 0, 0, 0, 32'h3010, 1, 26'h0000C10, 0, 0);
        step(0, 0, 0, 0, 32'h3010, 1, 26'h0000C10, 1, 32'h5000);
        step(1, 1, 1, 32'h0000_000C, 32'h30F0, 0, 0, 0, 0);
        step(1, 1, 1, 32'h0000_000C, 32'h30F0, 0, 0, 0, 0);
        step(0, 1, 1, 32'h0000_000C, 32'h30F0, 0, 0, 0, 0);
        idle(0);
        step(0, 0, 0, 0, 0, 0, 0, 1, 32'hFFFF_FFFC);
        idle(0);
        idle(0);
        step(0, 0, 0, 0, 0, 0, 0, 1, 32'h0000_3002);
        idle(0);
        idle(0);
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 60) == 0) begin
                do_reset();
            end else begin
                r = $urandom;
                step($urandom_range(0, 3) == 0,
                     $urandom_range(0, 3) == 0, r[0],
                     {{14{r[17]}}, r[17:2], 2'b00},
                     $urandom & ~32'd3,
                     $urandom_range(0, 5) == 0, 26'($urandom),
                     $urandom_range(0, 6) == 0,
                     $urandom_range(0, 3) == 0 ? $urandom
                                               : ($urandom & ~32'd3));
            end
        end
        idle(0);
        wait_cyc = 0;
        while (q.size() > 0 && wait_cyc < 10) begin
            @(posedge clk);
            wait_cyc++;
        end
        #2;
        if (q.size() > 0) begin
            n_chk++;
            $display("FAIL drain: %0d entries left, expected 0", q.size());
        end
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
